instr_fetch: RTL and testbench

- Front-end of the RISC core; the opposite end of the PC/counter interface.
- Reads each 16-bit instruction from byte-wide program memory at `pc_addr` as two beats, high byte first. Drives `pc_inc` (counter enable) after each beat.
- Splits the instruction into opcode and `ir_addr` and hands it to the machine controller over a valid/ready handshake.
- Resolves JMP locally with `pc_load`/`ir_addr`. Resolves HLT locally by halting.

---
 rtl/risc_pkg.sv | 26 ++
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core: bus widths, opcode encodings and
// the instruction-fetch state type.
package risc_pkg;

   localparam int unsigned DEF_ADDR_W = 13;
   localparam int unsigned DEF_OP_W   = 3;
   localparam int unsigned DEF_BYTE_W = 8;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   typedef enum logic [2:0] {
      S_HI,
      S_LO,
      S_DEC,
      S_OUT,
      S_HALT
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: reads each instruction as two program-memory bytes,
// resolves JMP/HLT locally and hands everything else to the controller.
module instr_fetch
   import risc_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned OP_W   = DEF_OP_W,
   parameter int unsigned BYTE_W = DEF_BYTE_W
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic              pc_inc,
   output logic              pc_load,
   output logic [ADDR_W-1:0] ir_addr,
   output logic [OP_W-1:0]   opcode,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [BYTE_W-1:0] mem_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              resume,
   output logic              halted
);

   localparam int unsigned IR_W = 2 * BYTE_W;

   if (ADDR_W + OP_W != IR_W) begin : g_bad_width
      $error("instr_fetch: ADDR_W + OP_W must equal 2*BYTE_W");
   end

   fetch_state_t      state;
   logic [IR_W-1:0]   ir;
   logic              is_jmp;
   logic              is_hlt;

   assign opcode   = ir[IR_W-1 -: OP_W];
   assign ir_addr  = ir[ADDR_W-1:0];
   assign mem_addr = pc_addr;
   assign is_jmp   = (opcode == OP_W'(OP_JMP));
   assign is_hlt   = (opcode == OP_W'(OP_HLT));

   // Counter controls are combinational so the PC moves on the beat's own
   // edge; gating with rst keeps a reset-cycle mem_ready from advancing it.
   always_comb begin
      pc_inc  = mem_rd & mem_ready & ~rst;
      pc_load = (state == S_DEC) & is_jmp & ~rst;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state       <= S_HI;
         ir          <= '0;
         mem_rd      <= 1'b1;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state)
            S_HI: begin
               if (mem_ready) begin
                  ir[IR_W-1:BYTE_W] <= mem_data;
                  state             <= S_LO;
               end
            end
            S_LO: begin
               if (mem_ready) begin
                  ir[BYTE_W-1:0] <= mem_data;
                  mem_rd         <= 1'b0;
                  state          <= S_DEC;
               end
            end
            S_DEC: begin
               if (is_jmp) begin
                  mem_rd <= 1'b1;
                  state  <= S_HI;
               end else if (is_hlt) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  instr_valid <= 1'b1;
                  state       <= S_OUT;
               end
            end
            S_OUT: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  mem_rd      <= 1'b1;
                  state       <= S_HI;
               end
            end
            S_HALT: begin
               if (resume) begin
                  halted <= 1'b0;
                  mem_rd <= 1'b1;
                  state  <= S_HI;
               end
            end
            default: begin
               instr_valid <= 1'b0;
               halted      <= 1'b0;
               mem_rd      <= 1'b1;
               state       <= S_HI;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: plays the PC counter and program memory, runs a
// vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_instr_fetch;

   logic        clock = 1'b0;
   logic        rst = 1'b0;
   logic [12:0] pc_addr;
   logic        pc_inc, pc_load, mem_rd, instr_valid, halted;
   logic [12:0] ir_addr, mem_addr;
   logic [2:0]  opcode;
   logic        mem_ready = 1'b0;
   logic [7:0]  mem_data;
   logic        instr_ready = 1'b0;
   logic        resume = 1'b0;

   logic [7:0]  mem [0:8191];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [12:0] model_pc;

   instr_fetch #(.ADDR_W(13), .OP_W(3), .BYTE_W(8)) dut (
      .clock(clock), .rst(rst), .pc_addr(pc_addr), .pc_inc(pc_inc),
      .pc_load(pc_load), .ir_addr(ir_addr), .opcode(opcode), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .resume(resume),
      .halted(halted)
   );

   always #5 clock = ~clock;

   // PC counter on the other side of the interface.
   always @(posedge clock) begin
      if (rst)          pc_addr <= '0;
      else if (pc_load) pc_addr <= ir_addr;
      else if (pc_inc)  pc_addr <= pc_addr + 13'd1;
   end

   assign mem_data = mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clock);
      #1 rst = 1'b0;
      #1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (!instr_valid && n < budget) begin
         cyc();
         n++;
      end
      chk(name, instr_valid, 1'b1);
   endtask

   // Reference: instructions consumed in program order from model_pc.
   task automatic model_fetch(output logic [15:0] w);
      w = {mem[model_pc], mem[model_pc + 13'd1]};
      model_pc = model_pc + 13'd2;
   endtask

   typedef struct {
      logic [15:0] word;
      logic [2:0]  exp_op;
      logic [12:0] exp_addr;
      int          kind;   // 0 = presented, 1 = jump, 2 = halt
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [15:0] w;
      logic [3:0]  pat;
      int          transfers;
      logic        prev_halted;

      vecs[0] = '{16'h4123, 3'd2, 13'h0123, 0};
      vecs[1] = '{16'hE0A5, 3'd7, 13'h00A5, 1};
      vecs[2] = '{16'h0000, 3'd0, 13'h0000, 2};
      vecs[3] = '{16'h3FFF, 3'd1, 13'h1FFF, 0};
      vecs[4] = '{16'hBABE, 3'd5, 13'h1ABE, 0};
      vecs[5] = '{16'hFFFF, 3'd7, 13'h1FFF, 1};
      vecs[6] = '{16'h1234, 3'd0, 13'h1234, 2};
      vecs[7] = '{16'hC001, 3'd6, 13'h0001, 0};

      for (int unsigned i = 0; i < 8192; i++) mem[i] = 8'h00;

      // Table: zero-wait fetch, outcome checked in S_DEC and the cycle after.
      for (int i = 0; i < 8; i++) begin
         mem[0] = vecs[i].word[15:8];
         mem[1] = vecs[i].word[7:0];
         mem_ready = 1'b1;
         instr_ready = 1'b0;
         do_reset();
         if (i == 0) begin
            chk("reset_valid", instr_valid, 1'b0);
            chk("reset_halted", halted, 1'b0);
            chk("reset_pc_load", pc_load, 1'b0);
         end
         chk("tbl_inc_hi", pc_inc, 1'b1);
         chk("tbl_rd_hi", mem_rd, 1'b1);
         cyc();
         chk("tbl_inc_lo", pc_inc, 1'b1);
         cyc();
         chk("tbl_dec_load", pc_load, vecs[i].kind == 1);
         chk("tbl_dec_inc", pc_inc, 1'b0);
         chk("tbl_dec_rd", mem_rd, 1'b0);
         chk("tbl_dec_pc", pc_addr, 13'd2);
         cyc();
         chk("tbl_valid", instr_valid, vecs[i].kind == 0);
         chk("tbl_halted", halted, vecs[i].kind == 2);
         chk("tbl_opcode", opcode, vecs[i].exp_op);
         chk("tbl_ir_addr", ir_addr, vecs[i].exp_addr);
         if (vecs[i].kind == 1) begin
            chk("tbl_jmp_addr", mem_addr, vecs[i].exp_addr);
            chk("tbl_jmp_rd", mem_rd, 1'b1);
         end
      end
      mem[0] = 8'h41;
      mem[1] = 8'h23;

      // Wait states: ready only on every 4th cycle of each beat.
      mem_ready = 1'b0;
      instr_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         pat = 4'b1000;
         mem_ready = pat[k % 4];
         #1;
         chk("ws_pc_inc", pc_inc, pat[k % 4]);
         cyc();
      end
      mem_ready = 1'b0;
      chk("ws_pc", pc_addr, 13'd2);
      wait_valid("ws_valid_timeout", 5);
      chk("ws_word", {opcode, ir_addr}, 16'h4123);

      // Backpressure: hold in S_OUT, a stray resume must be ignored.
      mem_ready = 1'b1;
      do_reset();
      wait_valid("bp_valid_timeout", 6);
      resume = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("bp_valid", instr_valid, 1'b1);
         chk("bp_word", {opcode, ir_addr}, 16'h4123);
         chk("bp_rd", mem_rd, 1'b0);
         chk("bp_halted", halted, 1'b0);
      end
      resume = 1'b0;
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;
      #1;
      chk("bp_after_valid", instr_valid, 1'b0);
      chk("bp_after_rd", mem_rd, 1'b1);
      chk("bp_after_addr", mem_addr, 13'd2);

      // Halt, hold 10 cycles, resume fetches from PC+2.
      mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h41; mem[3] = 8'h23;
      mem_ready = 1'b1;
      instr_ready = 1'b1;
      do_reset();
      for (int n = 0; n < 8 && !halted; n++) cyc();
      chk("hlt_enter", halted, 1'b1);
      for (int k = 0; k < 10; k++) begin
         chk("hlt_halted", halted, 1'b1);
         chk("hlt_rd", mem_rd, 1'b0);
         chk("hlt_inc", pc_inc, 1'b0);
         cyc();
      end
      chk("hlt_pc", pc_addr, 13'd2);
      resume = 1'b1;
      cyc();
      resume = 1'b0;
      #1;
      chk("hlt_resume", halted, 1'b0);
      chk("hlt_resume_rd", mem_rd, 1'b1);
      chk("hlt_resume_addr", mem_addr, 13'd2);
      instr_ready = 1'b0;
      wait_valid("hlt_next_timeout", 6);
      chk("hlt_next_word", {opcode, ir_addr}, 16'h4123);
      mem[0] = 8'h41; mem[1] = 8'h23;

      // Reset landing in S_LO with mem_ready high.
      mem_ready = 1'b1;
      do_reset();
      cyc();
      rst = 1'b1;
      #1;
      chk("rlo_no_inc", pc_inc, 1'b0);
      @(posedge clock);
      #1 rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk("rlo_rd", mem_rd, 1'b1);
      chk("rlo_valid", instr_valid, 1'b0);
      chk("rlo_ir", {opcode, ir_addr}, 16'h0000);
      chk("rlo_pc", pc_addr, 13'd0);
      cyc();
      chk("rlo_stay_hi", {opcode, ir_addr}, 16'h0000);

      // Randomized run against a program-order scoreboard.
      for (int unsigned i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      model_pc = '0;
      transfers = 0;
      prev_halted = 1'b0;
      mem_ready = 1'b0;
      instr_ready = 1'b0;
      resume = 1'b0;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         mem_ready = ($urandom_range(0, 9) < 7);
         instr_ready = ($urandom_range(0, 1) == 1);
         resume = halted && ($urandom_range(0, 2) == 0);
         #1;
         chk("rnd_excl", pc_inc & pc_load, 1'b0);
         chk("rnd_inc_rd", pc_inc & ~mem_rd, 1'b0);
         chk("rnd_mem_addr", mem_addr, pc_addr);
         if (pc_load) begin
            model_fetch(w);
            chk("rnd_jmp_word", {opcode, ir_addr}, w);
            chk("rnd_jmp_op", opcode, 3'd7);
            chk("rnd_jmp_pc", pc_addr, model_pc);
            model_pc = w[12:0];
         end
         if (halted && !prev_halted) begin
            model_fetch(w);
            chk("rnd_hlt_word", {opcode, ir_addr}, w);
            chk("rnd_hlt_op", opcode, 3'd0);
            chk("rnd_hlt_pc", pc_addr, model_pc);
         end
         if (instr_valid && instr_ready) begin
            model_fetch(w);
            chk("rnd_xfer_word", {opcode, ir_addr}, w);
            chk("rnd_xfer_kind", (opcode == 3'd0) || (opcode == 3'd7), 1'b0);
            chk("rnd_xfer_pc", pc_addr, model_pc);
            transfers++;
         end
         prev_halted = halted;
         cyc();
      end
      chk("rnd_progress", transfers > 50, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
